serie_paralelo_rx: RTL and testbench
====================================

SERIE_PARALELO_RX -- requirements
Module: serie_paralelo_rx

Interface
REQ-001 Parameter: BC_COUNT, 4, number of consecutive aligned idle bytes (8'hBC) required before entering ACTIVE; legal range 2..7.
REQ-002 Parameter: IDLE_BYTE, 8'hBC, comma/idle byte used for alignment and invalid-data marking.
REQ-003 clk_8f  input  1  bit clock; all state updates on posedge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 data_in  input  1  serial bit stream, MSB of each byte first.
REQ-006 data_out  output  8  last received aligned byte, registered.
REQ-007 valid_out  output  1  high when data_out holds a non-idle byte received in ACTIVE.
REQ-008 byte_strobe  output  1  one-cycle pulse marking a data_out update.
REQ-009 active  output  1  high while the FSM is in ACTIVE.

Function
REQ-010 Every posedge SHALL shift: sr <= {sr[6:0], data_in}; nxt denotes {sr[6:0], data_in}.
REQ-011 FSM states SHALL be SEARCH, SYNC, ACTIVE; the reset state SHALL be SEARCH.
REQ-012 In SEARCH, each cycle with nxt == IDLE_BYTE SHALL move to SYNC, set bc_cnt to 1 and set bit_cnt to 0 (bit-level alignment at any offset).
REQ-013 In SYNC and ACTIVE, bit_cnt (3-bit) SHALL increment every cycle and wrap 7->0; a cycle with bit_cnt == 7 is a byte boundary, and nxt is then the complete byte.
REQ-014 In SYNC at a boundary with nxt == IDLE_BYTE: bc_cnt SHALL increment, and if the new value equals BC_COUNT the FSM SHALL enter ACTIVE.
REQ-015 In SYNC at a boundary with nxt != IDLE_BYTE: the FSM SHALL return to SEARCH with bc_cnt = 0; that same nxt SHALL NOT be re-tested as a comma in that cycle.
REQ-016 ACTIVE SHALL persist until reset; data content never causes loss of sync.
REQ-017 In ACTIVE at each boundary: data_out <= nxt, valid_out <= (nxt != IDLE_BYTE), and byte_strobe SHALL pulse for exactly one cycle.
REQ-018 Between boundaries, data_out and valid_out SHALL hold their values.
REQ-019 Latency: data_out SHALL update on the same edge that samples the byte's last bit (zero extra cycles).
REQ-020 In SEARCH and SYNC, data_out, valid_out and byte_strobe SHALL stay 0.
REQ-021 active SHALL be registered and equal (state == ACTIVE); it rises on the edge that completes the BC_COUNT-th idle byte.

Reset
REQ-022 reset low SHALL immediately force sr, bit_cnt, bc_cnt, data_out, valid_out, byte_strobe and active to 0, and the state to SEARCH, independent of clk_8f.
REQ-023 Deassertion SHALL take effect at the first posedge with reset high; reset asserted mid-byte or mid-ACTIVE discards all partial data.

Structure
REQ-024 A shared package SHALL hold IDLE_BYTE (8'hBC), the default BC_COUNT and the state encoding, for reuse by the paralelo-serie transmitter.
REQ-025 The block SHALL be a single module; no sub-module is required.

Verification
REQ-026 Four 0xBC bytes then 0xA5, starting at the first post-reset edge -> SYNC at edge 8, active=1 after edge 32, data_out=0xA5, valid_out=1 and byte_strobe=1 for one cycle after edge 40.
REQ-027 Three random bits, then four 0xBC, then 0x3C -> all events shifted by 3 edges; data_out=0x3C after edge 43.
REQ-028 0xBC, 0xBC, 0x00, ... -> SYNC, then back to SEARCH at edge 24; active remains 0 and byte_strobe never pulses.
REQ-029 In ACTIVE, send 0x12 then 0xBC -> data_out=0x12 with valid_out=1, then data_out=0xBC with valid_out=0; both bytes strobe.
REQ-030 Assert reset low between clock edges while ACTIVE -> all outputs 0 immediately; after release, four 0xBC bytes are needed before active=1.
REQ-031 All-zero stream for 100 edges after reset -> stays in SEARCH; all outputs remain 0.

Source files
------------

// File: rtl/serie_paralelo_rx_pkg.sv
// Shared definitions for the serie-paralelo receiver and the paralelo-serie transmitter:
// comma byte, default alignment depth and the link FSM state encoding.
package serie_paralelo_rx_pkg;

  localparam logic [7:0] IDLE_BYTE_DEF = 8'hBC;
  localparam int         BC_COUNT_DEF  = 4;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SYNC   = 2'd1,
    ACTIVE = 2'd2
  } sp_state_t;

  function automatic logic is_comma(input logic [7:0] b, input logic [7:0] idle);
    return b == idle;
  endfunction

endpackage

// File: rtl/serie_paralelo_rx.sv
// Serial-to-parallel receiver: bit-aligns on a run of comma bytes, then emits every
// aligned byte on data_out with a one-cycle strobe; non-comma bytes are flagged valid.
module serie_paralelo_rx
  import serie_paralelo_rx_pkg::*;
#(
  parameter int         BC_COUNT  = BC_COUNT_DEF,
  parameter logic [7:0] IDLE_BYTE = IDLE_BYTE_DEF
) (
  input  logic       clk_8f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_strobe,
  output logic       active
);

  localparam logic [2:0] BC_TARGET = 3'(BC_COUNT);

  sp_state_t  state;
  logic [7:0] sr;
  logic [2:0] bit_cnt;
  logic [2:0] bc_cnt;
  logic [7:0] nxt;
  logic       boundary;
  logic       nxt_idle;

  // nxt already contains the bit being sampled, so a byte is complete on its last edge
  always_comb begin
    nxt      = {sr[6:0], data_in};
    boundary = (bit_cnt == 3'd7);
    nxt_idle = is_comma(nxt, IDLE_BYTE);
  end

  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) begin
      state       <= SEARCH;
      sr          <= '0;
      bit_cnt     <= '0;
      bc_cnt      <= '0;
      data_out    <= '0;
      valid_out   <= 1'b0;
      byte_strobe <= 1'b0;
      active      <= 1'b0;
    end else begin
      sr          <= nxt;
      byte_strobe <= 1'b0;
      unique case (state)
        SEARCH: begin
          if (nxt_idle) begin
            state   <= SYNC;
            bc_cnt  <= 3'd1;
            bit_cnt <= '0;
          end
        end
        SYNC: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (boundary) begin
            if (nxt_idle) begin
              bc_cnt <= bc_cnt + 3'd1;
              if (bc_cnt + 3'd1 == BC_TARGET) begin
                state  <= ACTIVE;
                active <= 1'b1;
              end
            end else begin
              // misaligned byte: drop back without re-testing it as a comma
              state   <= SEARCH;
              bc_cnt  <= '0;
              bit_cnt <= '0;
            end
          end
        end
        ACTIVE: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (boundary) begin
            data_out    <= nxt;
            valid_out   <= !nxt_idle;
            byte_strobe <= 1'b1;
          end
        end
        default: begin
          state  <= SEARCH;
          active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serie_paralelo_rx.sv
// Self-checking bench for serie_paralelo_rx: directed scenarios plus random streams
// compared against an edge-count based reference model.
module tb_serie_paralelo_rx;

  localparam int         BCN = 4;
  localparam logic [7:0] BC  = 8'hBC;

  logic       clk_8f  = 1'b0;
  logic       reset   = 1'b0;
  logic       data_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_strobe;
  logic       active;

  int checks = 0;
  int errors = 0;

  serie_paralelo_rx #(.BC_COUNT(BCN), .IDLE_BYTE(BC)) dut (
    .clk_8f      (clk_8f),
    .reset       (reset),
    .data_in     (data_in),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .byte_strobe (byte_strobe),
    .active      (active)
  );

  always #5 clk_8f = ~clk_8f;

  // Reference model: lock position is remembered as an edge number; byte boundaries
  // are the edges a whole multiple of 8 after it.
  int         edge_n, anchor, commas, mmode;
  logic [7:0] win, m_data;
  logic       m_valid, m_strobe, m_active;

  always @(posedge clk_8f or negedge reset) begin
    if (!reset) begin
      edge_n = 0; anchor = 0; commas = 0; mmode = 0;
      win = 8'h00; m_data = 8'h00; m_valid = 1'b0; m_strobe = 1'b0; m_active = 1'b0;
    end else begin
      edge_n   = edge_n + 1;
      win      = {win[6:0], data_in};
      m_strobe = 1'b0;
      if (mmode == 0) begin
        if (win == BC) begin mmode = 1; anchor = edge_n; commas = 1; end
      end else if (((edge_n - anchor) % 8) == 0) begin
        if (mmode == 1) begin
          if (win == BC) begin
            commas = commas + 1;
            if (commas == BCN) mmode = 2;
          end else begin
            mmode = 0; commas = 0;
          end
        end else begin
          m_data = win; m_valid = (win != BC); m_strobe = 1'b1;
        end
      end
      m_active = (mmode == 2);
    end
  end

  logic stim[$];

  function automatic void add_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) stim.push_back(b[i]);
  endfunction

  task automatic send_bit(input logic b);
    data_in = b;
    @(posedge clk_8f);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    @(posedge clk_8f); #1;
    @(posedge clk_8f); #1;
    reset = 1'b1;
  endtask

  task automatic test_reset;
    @(posedge clk_8f); #1;
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", data_out); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_out); end
    checks++; if (byte_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b expected 0", byte_strobe); end
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b expected 0", active); end
  endtask

  task automatic test_lock;
    int k;
    do_reset();
    for (int i = 0; i < 4; i++) add_byte(BC);
    add_byte(8'hA5); add_byte(8'h00);
    k = 0;
    while (stim.size() > 0) begin
      send_bit(stim.pop_front()); k++;
      checks++;
      if ({data_out, valid_out, byte_strobe, active} !== {m_data, m_valid, m_strobe, m_active}) begin
        errors++;
        $display("FAIL lock_model edge %0d: got %h/%b/%b/%b expected %h/%b/%b/%b", k,
                 data_out, valid_out, byte_strobe, active, m_data, m_valid, m_strobe, m_active);
      end
      if (k == 31) begin checks++; if (active !== 1'b0) begin errors++; $display("FAIL lock_early edge 31: active=%b expected 0", active); end end
      if (k == 32) begin checks++; if (active !== 1'b1) begin errors++; $display("FAIL lock_active edge 32: active=%b expected 1", active); end end
      if (k == 40) begin
        checks++;
        if ({data_out, valid_out, byte_strobe} !== {8'hA5, 1'b1, 1'b1}) begin
          errors++; $display("FAIL lock_byte edge 40: got %h/%b/%b expected a5/1/1", data_out, valid_out, byte_strobe);
        end
      end
      if (k == 41) begin
        checks++;
        if ({data_out, valid_out, byte_strobe} !== {8'hA5, 1'b1, 1'b0}) begin
          errors++; $display("FAIL lock_hold edge 41: got %h/%b/%b expected a5/1/0", data_out, valid_out, byte_strobe);
        end
      end
    end
  endtask

  task automatic test_offset;
    int k;
    do_reset();
    for (int i = 0; i < 3; i++) stim.push_back(1'($urandom_range(0, 1)));
    for (int i = 0; i < 4; i++) add_byte(BC);
    add_byte(8'h3C);
    k = 0;
    while (stim.size() > 0) begin
      send_bit(stim.pop_front()); k++;
      checks++;
      if ({data_out, valid_out, byte_strobe, active} !== {m_data, m_valid, m_strobe, m_active}) begin
        errors++;
        $display("FAIL offset_model edge %0d: got %h/%b/%b/%b expected %h/%b/%b/%b", k,
                 data_out, valid_out, byte_strobe, active, m_data, m_valid, m_strobe, m_active);
      end
      if (k == 34) begin checks++; if (active !== 1'b0) begin errors++; $display("FAIL offset_early edge 34: active=%b expected 0", active); end end
      if (k == 35) begin checks++; if (active !== 1'b1) begin errors++; $display("FAIL offset_active edge 35: active=%b expected 1", active); end end
      if (k == 43) begin
        checks++;
        if ({data_out, valid_out, byte_strobe} !== {8'h3C, 1'b1, 1'b1}) begin
          errors++; $display("FAIL offset_byte edge 43: got %h/%b/%b expected 3c/1/1", data_out, valid_out, byte_strobe);
        end
      end
    end
  endtask

  task automatic test_false_sync;
    int k, bad;
    do_reset();
    add_byte(BC); add_byte(BC); add_byte(8'h00); add_byte(8'h00);
    for (int i = 0; i < 4; i++) add_byte(BC);
    add_byte(8'h5A);
    k = 0; bad = 0;
    while (stim.size() > 0) begin
      send_bit(stim.pop_front()); k++;
      checks++;
      if ({data_out, valid_out, byte_strobe, active} !== {m_data, m_valid, m_strobe, m_active}) begin
        errors++;
        $display("FAIL false_sync_model edge %0d: got %h/%b/%b/%b expected %h/%b/%b/%b", k,
                 data_out, valid_out, byte_strobe, active, m_data, m_valid, m_strobe, m_active);
      end
      if (k <= 40 && (byte_strobe !== 1'b0 || active !== 1'b0)) bad++;
      if (k == 64) begin checks++; if (active !== 1'b1) begin errors++; $display("FAIL relock_active edge 64: active=%b expected 1", active); end end
      if (k == 72) begin
        checks++;
        if ({data_out, valid_out, byte_strobe} !== {8'h5A, 1'b1, 1'b1}) begin
          errors++; $display("FAIL relock_byte edge 72: got %h/%b/%b expected 5a/1/1", data_out, valid_out, byte_strobe);
        end
      end
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL false_sync_quiet: %0d edges with strobe/active, expected 0", bad); end
  endtask

  task automatic test_data_idle;
    int k;
    do_reset();
    for (int i = 0; i < 4; i++) add_byte(BC);
    add_byte(8'h12); add_byte(BC);
    for (int i = 0; i < 16; i++) add_byte(($urandom_range(0, 3) == 0) ? BC : 8'($urandom));
    k = 0;
    while (stim.size() > 0) begin
      send_bit(stim.pop_front()); k++;
      checks++;
      if ({data_out, valid_out, byte_strobe, active} !== {m_data, m_valid, m_strobe, m_active}) begin
        errors++;
        $display("FAIL data_idle_model edge %0d: got %h/%b/%b/%b expected %h/%b/%b/%b", k,
                 data_out, valid_out, byte_strobe, active, m_data, m_valid, m_strobe, m_active);
      end
      if (k == 40 && {data_out, valid_out, byte_strobe} !== {8'h12, 1'b1, 1'b1}) begin
        errors++; $display("FAIL data_byte edge 40: got %h/%b/%b expected 12/1/1", data_out, valid_out, byte_strobe);
      end
      if (k == 44 && {data_out, valid_out, byte_strobe} !== {8'h12, 1'b1, 1'b0}) begin
        errors++; $display("FAIL data_hold edge 44: got %h/%b/%b expected 12/1/0", data_out, valid_out, byte_strobe);
      end
      if (k == 48 && {data_out, valid_out, byte_strobe} !== {BC, 1'b0, 1'b1}) begin
        errors++; $display("FAIL idle_byte edge 48: got %h/%b/%b expected bc/0/1", data_out, valid_out, byte_strobe);
      end
      if (k == 40 || k == 44 || k == 48) checks++;
    end
    checks++;
    if (active !== 1'b1) begin errors++; $display("FAIL active_persist: active=%b expected 1", active); end
  endtask

  task automatic test_reset_mid;
    int k;
    do_reset();
    for (int i = 0; i < 4; i++) add_byte(BC);
    add_byte(8'h77);
    for (int i = 0; i < 3; i++) stim.push_back(1'($urandom_range(0, 1)));
    while (stim.size() > 0) send_bit(stim.pop_front());
    checks++;
    if ({data_out, valid_out, active} !== {8'h77, 1'b1, 1'b1}) begin
      errors++; $display("FAIL pre_reset: got %h/%b/%b expected 77/1/1", data_out, valid_out, active);
    end
    #3 reset = 1'b0;
    #1;
    checks++;
    if ({data_out, valid_out, byte_strobe, active} !== 11'h0) begin
      errors++; $display("FAIL async_reset: got %h/%b/%b/%b expected 00/0/0/0", data_out, valid_out, byte_strobe, active);
    end
    @(posedge clk_8f); #1;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) add_byte(BC);
    k = 0;
    while (stim.size() > 0) begin
      send_bit(stim.pop_front()); k++;
      checks++;
      if ({data_out, valid_out, byte_strobe, active} !== {m_data, m_valid, m_strobe, m_active}) begin
        errors++;
        $display("FAIL reset_mid_model edge %0d: got %h/%b/%b/%b expected %h/%b/%b/%b", k,
                 data_out, valid_out, byte_strobe, active, m_data, m_valid, m_strobe, m_active);
      end
      if (k == 31) begin checks++; if (active !== 1'b0) begin errors++; $display("FAIL relock_early edge 31: active=%b expected 0", active); end end
    end
    checks++;
    if (active !== 1'b1) begin errors++; $display("FAIL relock_after_reset: active=%b expected 1", active); end
  endtask

  task automatic test_zeros;
    int bad;
    do_reset();
    bad = 0;
    for (int k = 1; k <= 100; k++) begin
      send_bit(1'b0);
      if ({data_out, valid_out, byte_strobe, active} !== 11'h0) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL zeros_quiet: %0d edges with nonzero outputs, expected 0", bad); end
  endtask

  task automatic test_random;
    int k;
    for (int rep = 0; rep < 3; rep++) begin
      do_reset();
      for (int i = 0; i < 12; i++) stim.push_back(1'($urandom_range(0, 1)));
      for (int i = 0; i < 4; i++) add_byte(($urandom_range(0, 5) == 0) ? 8'($urandom) : BC);
      for (int i = 0; i < 30; i++) add_byte(($urandom_range(0, 3) == 0) ? BC : 8'($urandom));
      k = 0;
      while (stim.size() > 0) begin
        send_bit(stim.pop_front()); k++;
        checks++;
        if ({data_out, valid_out, byte_strobe, active} !== {m_data, m_valid, m_strobe, m_active}) begin
          errors++;
          $display("FAIL random_model run %0d edge %0d: got %h/%b/%b/%b expected %h/%b/%b/%b", rep, k,
                   data_out, valid_out, byte_strobe, active, m_data, m_valid, m_strobe, m_active);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_offset();
    test_false_sync();
    test_data_idle();
    test_reset_mid();
    test_zeros();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
